strhw_ns_update: RTL and testbench
==================================

# strhw_ns_update

Post-compression accumulator stage of the Streebog datapath. After g_N finishes a block, this block advances the length counter N by the block's bit length and adds the message block to the checksum Sigma, both modulo 2^512. Results feed the next g_N iteration and the finalisation step. The 512-bit additions run as a multi-cycle limb-serial carry chain to keep the adders small.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- trg_i  in  1  start pulse; sampled only in IDLE or DONE
- m_i  in  512  message block to add into Sigma
- n_i  in  512  current N
- sigma_i  in  512  current Sigma
- len_i  in  10  bit length of the block, 0..512
- n_o  out  512  updated N; registered, held between operations
- sigma_o  out  512  updated Sigma; registered, held between operations
- busy_o  out  1  high while in ADD
- done_o  out  1  one-cycle completion pulse; n_o/sigma_o valid while high and afterwards

## Operation
- States: IDLE, ADD, DONE. Reset enters IDLE.
- Start: trg_i=1 at an edge in IDLE or DONE:
  - captures m_i, n_i, sigma_i and the effective length into internal registers;
  - clears the carries and limb counter k;
  - enters ADD.
- Effective length is len_i if len_i ≤ 512, else 512 (saturate).
- Limb width: W=64 (8 limbs). Each ADD edge processes limb k for both sums in parallel:
  - Sigma limb = sigma[k] + m[k] + cs
  - N limb = n[k] + (k==0 ? len : 0) + cn
  - cs and cn take the carry-outs. k increments.
- After the last limb: carries are discarded (mod 2^512). n_o/sigma_o load the completed results. State goes to DONE.
- DONE lasts one cycle, with done_o=1.
  - Next edge with trg_i=0: go to IDLE.
  - Next edge with trg_i=1: start a new operation (go to ADD).
- trg_i in ADD is ignored; no queueing.
- n_o and sigma_o change only on the completing edge, never during ADD.
- Reset at any time, including mid-ADD:
  - n_o=0, sigma_o=0, busy_o=0, done_o=0;
  - internal registers and k cleared; state IDLE;
  - the aborted operation produces no done_o pulse.

## Timing
- Reset values: n_o=0, sigma_o=0, busy_o=0, done_o=0.
- Start sampled at edge E0. busy_o is high for cycles E0..E0+L.
- Limbs are processed at edges E0+1..E0+L, where L = 512/W.
- Results register at edge E0+L. done_o is high in the cycle after E0+L.
- Default latency: L=8. done_o is asserted 8 cycles after the start edge.
- Back-to-back throughput: one operation per L+1 cycles (restart from DONE).
- Inputs m_i/n_i/sigma_i/len_i need only be valid at the start edge.

## Configuration
- Macro STRHW_NS_UPDATE_WIDE_LIMB_EN.
  - Defined: W=128, L=4. done_o is asserted 4 cycles after the start edge.
  - Undefined: W=64, L=8.
- Results are bit-identical in both builds. Only latency and busy_o duration differ.

## Test plan
- Basic: n_i=0, sigma_i=0, m_i=1, len_i=512, trg_i pulse -> after L cycles, done_o=1 for one cycle, n_o=0x200, sigma_o=1. busy_o is high for exactly L cycles.
- Carry chain: n_i=0xFFFF_FFFF_FFFF_FE00, len_i=512; sigma_i=2^128-1, m_i=1 -> n_o=2^64, sigma_o=2^128. This checks carry across limb boundaries in both builds.
- Wrap-around: n_i=2^512-1, len_i=1; sigma_i=2^512-1, m_i=2^512-1 -> n_o=0, sigma_o=2^512-2.
- Length: len_i=0x3FF with n_i=0 -> n_o=0x200. len_i=0 -> n_o=n_i, and Sigma is still updated.
- Handshake:
  - trg_i held high through ADD with changing inputs -> only the start-edge operands are used, and there is one done_o pulse.
  - trg_i=1 in the DONE cycle -> second operation starts immediately, and its done_o arrives L+1 cycles after the first.
  - n_o/sigma_o hold their old values during ADD.
- Reset mid-operation: assert rst_ni low at limb 4 -> all outputs 0 immediately, no done_o. A fresh operation after release produces correct results.

Source files
------------

// File: rtl/strhw_ns_update.sv
// Streebog N/Sigma post-compression update: N += len, Sigma += m (mod 2^512) via limb-serial carry chain.
// Define STRHW_NS_UPDATE_WIDE_LIMB_EN for 128-bit limbs (4 cycles) instead of 64-bit limbs (8 cycles).
module strhw_ns_update (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         trg_i,
  input  logic [511:0] m_i,
  input  logic [511:0] n_i,
  input  logic [511:0] sigma_i,
  input  logic [9:0]   len_i,
  output logic [511:0] n_o,
  output logic [511:0] sigma_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned DW = 512;
  localparam int unsigned LW = 10;
`ifdef STRHW_NS_UPDATE_WIDE_LIMB_EN
  localparam int unsigned W = 128;
`else
  localparam int unsigned W = 64;
`endif
  localparam int unsigned L  = DW / W;
  localparam int unsigned KW = $clog2(L);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic            start_c, last_c;
  logic [KW-1:0]   k_q;
  logic [DW-1:0]   m_q, n_q, s_q;
  logic [LW-1:0]   len_q;
  logic            cs_q, cn_q;
  logic [LW-1:0]   len_eff_c, len_add_c;
  logic [W:0]      s_sum_c, n_sum_c;

  // Next-state logic; start accepted only from IDLE or DONE
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    last_c  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (trg_i) begin
          start_c = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        if (k_q == KW'(L - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Low limb of each operand register is the one being summed this cycle
  always_comb begin
    len_eff_c = (len_i > LW'(DW)) ? LW'(DW) : len_i;
    len_add_c = (k_q == '0) ? len_q : '0;
    s_sum_c   = {1'b0, s_q[W-1:0]} + {1'b0, m_q[W-1:0]} + (W+1)'(cs_q);
    n_sum_c   = {1'b0, n_q[W-1:0]} + (W+1)'(len_add_c) + (W+1)'(cn_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // n_q/s_q rotate: consumed limb leaves at the bottom, its sum enters at the top
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      len_q   <= '0;
      k_q     <= '0;
      cs_q    <= 1'b0;
      cn_q    <= 1'b0;
      n_o     <= '0;
      sigma_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      if (start_c) begin
        m_q   <= m_i;
        n_q   <= n_i;
        s_q   <= sigma_i;
        len_q <= len_eff_c;
        k_q   <= '0;
        cs_q  <= 1'b0;
        cn_q  <= 1'b0;
      end else if (state_q == ADD) begin
        m_q  <= m_q >> W;
        n_q  <= {n_sum_c[W-1:0], n_q[DW-1:W]};
        s_q  <= {s_sum_c[W-1:0], s_q[DW-1:W]};
        cs_q <= s_sum_c[W];
        cn_q <= n_sum_c[W];
        k_q  <= k_q + KW'(1);
      end
      if (last_c) begin
        n_o     <= {n_sum_c[W-1:0], n_q[DW-1:W]};
        sigma_o <= {s_sum_c[W-1:0], s_q[DW-1:W]};
      end
      busy_o <= (state_d == ADD);
      done_o <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_strhw_ns_update.sv
// Scoreboard bench for strhw_ns_update: stimulus pushes expected N/Sigma, a monitor pops on done_o.
module tb_strhw_ns_update;

`ifdef STRHW_NS_UPDATE_WIDE_LIMB_EN
  localparam int L = 4;
`else
  localparam int L = 8;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         trg_i;
  logic [511:0] m_i, n_i, sigma_i;
  logic [9:0]   len_i;
  logic [511:0] n_o, sigma_o;
  logic         busy_o, done_o;

  strhw_ns_update dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .trg_i   (trg_i),
    .m_i     (m_i),
    .n_i     (n_i),
    .sigma_i (sigma_i),
    .len_i   (len_i),
    .n_o     (n_o),
    .sigma_o (sigma_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [511:0] n;
    logic [511:0] s;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [511:0] cur_n = '0;
  logic [511:0] cur_s = '0;
  int           busy_run = 0;
  bit           skip_busy = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: results on done_o, held outputs otherwise, busy run length
  always @(negedge clk_i) begin
    exp_t e;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done_o=1 want no pending operation");
      end else begin
        e = exp_q.pop_front();
        chk("n_o", n_o, e.n);
        chk("sigma_o", sigma_o, e.s);
        cur_n = e.n;
        cur_s = e.s;
      end
    end else begin
      chk("n_o_hold", n_o, cur_n);
      chk("sigma_o_hold", sigma_o, cur_s);
    end
    if (busy_o) begin
      busy_run++;
    end else begin
      if (busy_run != 0 && !skip_busy) chk("busy_len", 512'(busy_run), 512'(L));
      busy_run = 0;
      skip_busy = 1'b0;
    end
  end

  task automatic start_op(input logic [511:0] m, input logic [511:0] n, input logic [511:0] s,
                          input logic [9:0] len, input logic [511:0] en, input logic [511:0] es);
    exp_t e;
    m_i = m; n_i = n; sigma_i = s; len_i = len; trg_i = 1'b1;
    e.n = en;
    e.s = es;
    exp_q.push_back(e);
  endtask

  task automatic scramble();
    m_i     = {16{$urandom()}};
    n_i     = {16{$urandom()}};
    sigma_i = {16{$urandom()}};
    len_i   = 10'($urandom());
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles want done_o", name, n);
    end
  endtask

  task automatic run_op(input string name, input logic [511:0] m, input logic [511:0] n,
                        input logic [511:0] s, input logic [9:0] len,
                        input logic [511:0] en, input logic [511:0] es);
    @(negedge clk_i);
    start_op(m, n, s, len, en, es);
    @(negedge clk_i);
    trg_i = 1'b0;
    scramble();
    wait_done(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    int t1, t2;
    rst_ni = 1'b1; trg_i = 1'b0;
    m_i = '0; n_i = '0; sigma_i = '0; len_i = '0;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_n_o", n_o, '0);
    chk("rst_sigma_o", sigma_o, '0);
    chk("rst_busy_o", 512'(busy_o), '0);
    chk("rst_done_o", 512'(done_o), '0);
    rst_ni = 1'b1;

    run_op("basic", 512'd1, '0, '0, 10'd512, 512'h200, 512'd1);
    run_op("carry", 512'd1, 512'hFFFF_FFFF_FFFF_FE00, (512'd1 << 128) - 512'd1, 10'd512,
           512'd1 << 64, 512'd1 << 128);
    run_op("wrap", {512{1'b1}}, {512{1'b1}}, {512{1'b1}}, 10'd1, '0, ~512'd1);
    run_op("top_carry", 512'd1 << 511, 512'hFFFF_FFFF_FFFF_FFFF, 512'd1 << 511, 10'd300,
           (512'd1 << 64) + 512'd299, '0);
    run_op("len_sat", 512'd5, '0, 512'd7, 10'h3FF, 512'h200, 512'd12);
    run_op("len_zero", 512'd32, 512'h1234_5678_9ABC_DEF0_1122_3344, 512'd16, 10'd0,
           512'h1234_5678_9ABC_DEF0_1122_3344, 512'd48);

    // trg_i held through ADD with changing operands
    @(negedge clk_i);
    start_op(512'd3, 512'd100, 512'd4, 10'd28, 512'd128, 512'd7);
    repeat (L - 2) begin
      @(negedge clk_i);
      scramble();
    end
    @(negedge clk_i);
    trg_i = 1'b0;
    wait_done("held_trg");

    // Back-to-back restart from DONE
    run_op("b2b_a", 512'd1 << 256, 512'd512, 512'd1 << 256, 10'd512, 512'd1024, 512'd1 << 257);
    t1 = cyc;
    start_op({512{1'b1}}, {512{1'b1}}, '0, 10'd2, 512'd1, {512{1'b1}});
    @(negedge clk_i);
    trg_i = 1'b0;
    scramble();
    wait_done("b2b_b");
    t2 = cyc;
    chk("b2b_spacing", 512'(t2 - t1), 512'(L + 1));

    // Reset mid-ADD: aborted operation must not complete
    @(negedge clk_i);
    start_op(512'd9, 512'd9, 512'd9, 10'd9, '0, '0);
    @(negedge clk_i);
    trg_i = 1'b0;
    repeat (L / 2) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    cur_n = '0;
    cur_s = '0;
    exp_q.delete();
    skip_busy = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("abort_n_o", n_o, '0);
    chk("abort_sigma_o", sigma_o, '0);
    chk("abort_busy_o", 512'(busy_o), '0);
    chk("abort_done_o", 512'(done_o), '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (L + 2) @(negedge clk_i);
    run_op("after_rst", 512'd2, 512'h10, 512'd1, 10'd16, 512'h20, 512'd3);

    repeat (L + 3) @(negedge clk_i);
    chk("pending", 512'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
